// File: rtl/fa_exhaustive_checker.sv
// Exhaustive BIST sequencer for a single full-adder cell: sweeps all 8 input vectors and checks s/cout.
// Optional build macro FACHK_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module fa_exhaustive_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       fa_a,
    output logic       fa_b,
    output logic       fa_cin,
    input  logic       fa_s,
    input  logic       fa_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

    state_t     state;
    logic [2:0] vec_idx;
    logic [7:0] settle_cnt;

    logic       exp_s;
    logic       exp_cout;
    logic       mismatch;
    logic       compare_edge;
    logic       last_vector;
    logic       end_sweep;
    logic [3:0] err_next;
    logic [2:0] vec_next;

    // Golden adder is derived from the index register, not from the DUT pins.
    always_comb begin
        exp_s        = vec_idx[2] ^ vec_idx[1] ^ vec_idx[0];
        exp_cout     = (vec_idx[2] & vec_idx[1]) | (vec_idx[2] & vec_idx[0]) | (vec_idx[1] & vec_idx[0]);
        mismatch     = (fa_s != exp_s) || (fa_cout != exp_cout);
        compare_edge = (state == DRIVE) && (settle_cnt == SETTLE_LAST);
        last_vector  = (vec_idx == 3'd7);
        err_next     = err_count + {3'b000, mismatch};
        vec_next     = vec_idx + 3'd1;
`ifdef FACHK_STOP_ON_FAIL_EN
        end_sweep    = last_vector || mismatch;
`else
        end_sweep    = last_vector;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_idx    <= 3'd0;
            settle_cnt <= 8'd0;
            fa_a       <= 1'b0;
            fa_b       <= 1'b0;
            fa_cin     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            fail_vec   <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        vec_idx    <= 3'd0;
                        settle_cnt <= 8'd0;
                        {fa_a, fa_b, fa_cin} <= 3'b000;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 4'd0;
                        fail_vec   <= 8'd0;
                    end
                end
                DRIVE: begin
                    if (compare_edge) begin
                        settle_cnt <= 8'd0;
                        if (mismatch) begin
                            fail_vec[vec_idx] <= 1'b1;
                            err_count         <= err_next;
                        end
                        // Results latch on the final compare edge, so pass must use the updated count.
                        if (end_sweep) begin
                            state   <= DONE;
                            vec_idx <= 3'd0;
                            {fa_a, fa_b, fa_cin} <= 3'b000;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next == 4'd0);
                        end else begin
                            vec_idx <= vec_next;
                            {fa_a, fa_b, fa_cin} <= vec_next;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Directed bench for fa_exhaustive_checker with a fault-injectable full-adder model on the far side.
// Expected results follow FACHK_STOP_ON_FAIL_EN when the build defines it.
module tb_fa_exhaustive_checker;

    localparam int SETTLE = 2;
    localparam int WINDOW = SETTLE + 1;
    localparam int FULL_LATENCY = 8 * WINDOW;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       fa_a, fa_b, fa_cin;
    logic       fa_s, fa_cout;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    // 0 = golden adder, 1 = cout stuck-at-0, 2 = inverted sum
    logic [1:0] fault_mode;

    int checks = 0;
    int errors = 0;

    fa_exhaustive_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_s      (fa_s),
        .fa_cout   (fa_cout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fa_s    = (fa_a ^ fa_b ^ fa_cin) ^ (fault_mode == 2'd2);
    assign fa_cout = (fault_mode == 2'd1) ? 1'b0 : ((fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin));

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Pulses (or holds) start from just after a rising edge and runs until done or the cycle budget expires.
    task automatic applyStimulus(input logic [1:0] fault, input bit hold_start, input int repulse_at,
                                 input bit check_vec, output int latency);
        int cyc;
        fault_mode = fault;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        checkOutput("start_edge_busy_done", {30'd0, busy, done}, 32'h2);
        cyc = 64;
        for (int j = 1; j <= 64; j++) begin
            if (j == repulse_at - 1) start = 1'b1;
            if (j == repulse_at) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                cyc = j;
                break;
            end
            if (check_vec) begin
                checkOutput($sformatf("vector_at_cycle_%0d", j), {29'd0, fa_a, fa_b, fa_cin}, 32'(j / WINDOW));
                checkOutput($sformatf("busy_at_cycle_%0d", j), {31'd0, busy}, 32'd1);
            end
        end
        latency = cyc;
    endtask

    int         lat;
    int         exp_lat_stuck, exp_lat_inv;
    logic [7:0] exp_fail_stuck, exp_fail_inv;
    logic [3:0] exp_err_stuck, exp_err_inv;

    initial begin
`ifdef FACHK_STOP_ON_FAIL_EN
        exp_lat_stuck = 4 * WINDOW;  exp_fail_stuck = 8'h08; exp_err_stuck = 4'd1;
        exp_lat_inv   = 1 * WINDOW;  exp_fail_inv   = 8'h01; exp_err_inv   = 4'd1;
`else
        exp_lat_stuck = FULL_LATENCY; exp_fail_stuck = 8'hE8; exp_err_stuck = 4'd4;
        exp_lat_inv   = FULL_LATENCY; exp_fail_inv   = 8'hFF; exp_err_inv   = 4'd8;
`endif
        fault_mode = 2'd0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {17'd0, fa_a, fa_b, fa_cin, busy, done, pass, err_count, fail_vec}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_reset", {30'd0, busy, done}, 32'd0);

        $display("[TB] golden sweep");
        applyStimulus(2'd0, 1'b0, 0, 1'b1, lat);
        checkOutput("golden_latency", 32'(lat), 32'(FULL_LATENCY));
        checkOutput("golden_results", {17'd0, busy, done, pass, err_count, fail_vec}, {17'd0, 3'b011, 4'd0, 8'h00});
        checkOutput("golden_fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_held", {30'd0, done, pass}, 32'h3);

        $display("[TB] cout stuck-at-0");
        applyStimulus(2'd1, 1'b0, 0, 1'b0, lat);
        checkOutput("stuck_latency", 32'(lat), 32'(exp_lat_stuck));
        checkOutput("stuck_fail_vec", {24'd0, fail_vec}, {24'd0, exp_fail_stuck});
        checkOutput("stuck_err_count", {28'd0, err_count}, {28'd0, exp_err_stuck});
        checkOutput("stuck_pass", {31'd0, pass}, 32'd0);
        checkOutput("stuck_fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);

        $display("[TB] inverted sum");
        applyStimulus(2'd2, 1'b0, 0, 1'b0, lat);
        checkOutput("inv_latency", 32'(lat), 32'(exp_lat_inv));
        checkOutput("inv_fail_vec", {24'd0, fail_vec}, {24'd0, exp_fail_inv});
        checkOutput("inv_err_count", {28'd0, err_count}, {28'd0, exp_err_inv});
        checkOutput("inv_pass", {31'd0, pass}, 32'd0);

        $display("[TB] reset during vector 4");
        fault_mode = 2'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4 * WINDOW) @(posedge clk);
        #1;
        checkOutput("pre_reset_vector4", {29'd0, fa_a, fa_b, fa_cin}, 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("midsweep_reset_outputs", {17'd0, fa_a, fa_b, fa_cin, busy, done, pass, err_count, fail_vec}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (FULL_LATENCY + 2) @(posedge clk);
        #1;
        checkOutput("no_result_after_abort", {30'd0, busy, done}, 32'd0);
        applyStimulus(2'd0, 1'b0, 0, 1'b0, lat);
        checkOutput("resweep_latency", 32'(lat), 32'(FULL_LATENCY));
        checkOutput("resweep_pass", {28'd0, pass, err_count[2:0]}, 32'h8);
        checkOutput("resweep_fail_vec", {24'd0, fail_vec}, 32'd0);

        $display("[TB] re-pulse while busy, then start held from done");
        applyStimulus(2'd0, 1'b0, 10, 1'b1, lat);
        checkOutput("repulse_latency", 32'(lat), 32'(FULL_LATENCY));
        checkOutput("repulse_pass", {31'd0, pass}, 32'd1);
        applyStimulus(2'd0, 1'b1, 0, 1'b1, lat);
        checkOutput("held_start_latency", 32'(lat), 32'(FULL_LATENCY));
        @(posedge clk); #1;
        checkOutput("back_to_back_restart", {30'd0, busy, done}, 32'h2);
        start = 1'b0;
        for (int j = 0; j < 64 && !done; j++) begin
            @(posedge clk); #1;
        end
        checkOutput("back_to_back_done", {30'd0, done, pass}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
